fpu_abs_add_div: RTL and testbench

- Single-precision (IEEE-754 binary32) arithmetic unit with three operations: absolute value (fabs), addition (fadd) and division (fdiv).
- Sits in the execute stage of the core's FP datapath, fed by the FP register-file read ports.
- Registered output: fabs/fadd complete in 1 cycle, fdiv in 2 cycles.

---
 rtl/fpu_pkg.sv | 85 ++++++++
 rtl/fpu_div_core.sv | 110 +++++++++++
 rtl/fpu_abs_add_div.sv | 155 +++++++++++++++
 tb/tb_fpu_abs_add_div.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types, constants and helpers for the binary32 abs/add/div unit.
// Helpers: operand classification, leading-zero count, mantissa divide, round-and-pack.
package fpu_pkg;

   typedef enum logic [1:0] {
      FP_ABS = 2'b00,
      FP_ADD = 2'b01,
      FP_DIV = 2'b10,
      FP_RSV = 2'b11
   } fp_op_e;

   localparam logic signed [9:0] EXP_BIAS = 10'sd127;
   localparam logic signed [9:0] EXP_MAX  = 10'sd255;
   localparam int                MANT_W   = 23;
   localparam logic [31:0]       QNAN     = 32'h7FC00000;
   localparam logic [31:0]       POS_INF  = 32'h7F800000;

   typedef struct packed {
      logic              sign;
      logic [7:0]        exp;
      logic [MANT_W-1:0] mant;
   } fp32_t;

   function automatic logic is_nan(input fp32_t v);
      return (v.exp == 8'hFF) && (v.mant != 23'd0);
   endfunction

   function automatic logic is_snan(input fp32_t v);
      return is_nan(v) && !v.mant[MANT_W-1];
   endfunction

   function automatic logic is_inf(input fp32_t v);
      return (v.exp == 8'hFF) && (v.mant == 23'd0);
   endfunction

   // Subnormals count as zero for arithmetic.
   function automatic logic is_zero(input fp32_t v);
      return v.exp == 8'd0;
   endfunction

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      n = 5'd27;
      for (int i = 0; i < 27; i++) begin
         n = v[i] ? 5'(26 - i) : n;
      end
      return n;
   endfunction

   // Restoring divide: {q[26:0], sticky}, q = floor(ma * 2^26 / mb).
   function automatic logic [27:0] div_mant(input logic [23:0] ma, input logic [23:0] mb);
      logic [24:0] rem;
      logic [26:0] q;
      rem = {1'b0, ma};
      q   = 27'd0;
      for (int i = 26; i >= 0; i--) begin
         q[i] = (rem >= {1'b0, mb});
         rem  = q[i] ? (rem - {1'b0, mb}) : rem;
         rem  = {rem[23:0], 1'b0};
      end
      return {q, rem != 25'd0};
   endfunction

   // sig[26] is the hidden bit, sig[2:0] are guard/round/sticky. RNE, then
   // flush-to-zero below the normal range and saturate to infinity above it.
   function automatic logic [31:0] round_pack(input logic sign, input logic signed [9:0] e_in,
                                              input logic [26:0] sig);
      logic              up;
      logic [24:0]       m;
      logic signed [9:0] e;
      logic [31:0]       r;
      up = sig[2] & (sig[3] | sig[1] | sig[0]);
      m  = {1'b0, sig[26:3]} + {24'd0, up};
      e  = m[24] ? (e_in + 10'sd1) : e_in;
      if (e < 10'sd1) begin
         r = {sign, 31'd0};
      end else if (e >= EXP_MAX) begin
         r = {sign, POS_INF[30:0]};
      end else begin
         r = {sign, e[7:0], (m[24] ? m[23:1] : m[22:0])};
      end
      return r;
   endfunction

endpackage

// File: rtl/fpu_div_core.sv
// Two-stage binary32 divider: stage 1 classifies operands and forms the quotient
// mantissa, stage 2 normalizes and rounds. Flags port exists only with FPU_STATUS_EN.
module fpu_div_core
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic        res_valid,
   output logic [31:0] res
`ifdef FPU_STATUS_EN
   ,
   output logic [3:0]  res_flags
`endif
);

   fp32_t             a_s, b_s;
   logic [27:0]       qd_s;
   logic signed [9:0] exp1_s;
   logic              sign_s, spec_s;
   logic [31:0]       spec_val_s;

   logic              s1_valid_r, s1_spec_r, s1_sign_r, s1_st_r;
   logic [31:0]       s1_spec_val_r;
   logic signed [9:0] s1_exp_r;
   logic [26:0]       s1_q_r;

   logic [26:0]       norm_s;
   logic signed [9:0] nexp_s;
   logic [31:0]       rnd_s;

`ifdef FPU_STATUS_EN
   logic              inv_s, dbz_s, s1_inv_r, s1_dbz_r;
`endif

   // Stage 1: operand classification, quotient mantissa and raw exponent
   always_comb begin
      a_s        = fp32_t'(x1);
      b_s        = fp32_t'(x2);
      qd_s       = div_mant({1'b1, a_s.mant}, {1'b1, b_s.mant});
      exp1_s     = $signed({2'b00, a_s.exp}) - $signed({2'b00, b_s.exp}) + EXP_BIAS;
      sign_s     = a_s.sign ^ b_s.sign;
      spec_s     = 1'b1;
      spec_val_s = QNAN;
      if (is_nan(a_s) || is_nan(b_s) || (is_zero(a_s) && is_zero(b_s)) ||
          (is_inf(a_s) && is_inf(b_s))) begin
         spec_val_s = QNAN;
      end else if (is_inf(a_s) || is_zero(b_s)) begin
         spec_val_s = {sign_s, POS_INF[30:0]};
      end else if (is_zero(a_s) || is_inf(b_s)) begin
         spec_val_s = {sign_s, 31'd0};
      end else begin
         spec_s = 1'b0;
      end
`ifdef FPU_STATUS_EN
      inv_s = is_snan(a_s) | is_snan(b_s) | (is_zero(a_s) & is_zero(b_s)) |
              (is_inf(a_s) & is_inf(b_s));
      dbz_s = is_zero(b_s) & !is_zero(a_s) & !is_inf(a_s) & !is_nan(a_s);
`endif
   end

   // Stage-1 pipeline register; reset discards an in-flight divide
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_r    <= 1'b0;
         s1_spec_r     <= 1'b0;
         s1_spec_val_r <= 32'd0;
         s1_sign_r     <= 1'b0;
         s1_exp_r      <= 10'sd0;
         s1_q_r        <= 27'd0;
         s1_st_r       <= 1'b0;
`ifdef FPU_STATUS_EN
         s1_inv_r      <= 1'b0;
         s1_dbz_r      <= 1'b0;
`endif
      end else begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_spec_r     <= spec_s;
            s1_spec_val_r <= spec_val_s;
            s1_sign_r     <= sign_s;
            s1_exp_r      <= exp1_s;
            s1_q_r        <= qd_s[27:1];
            s1_st_r       <= qd_s[0];
`ifdef FPU_STATUS_EN
            s1_inv_r      <= inv_s;
            s1_dbz_r      <= dbz_s;
`endif
         end
      end
   end

   // Stage 2: quotient is in (0.5, 2); shift once if below 1, then round
   always_comb begin
      norm_s = s1_q_r[26] ? {s1_q_r[26:1], s1_q_r[0] | s1_st_r} : {s1_q_r[25:0], s1_st_r};
      nexp_s = s1_q_r[26] ? s1_exp_r : (s1_exp_r - 10'sd1);
      rnd_s  = round_pack(s1_sign_r, nexp_s, norm_s);
      res    = s1_spec_r ? s1_spec_val_r : rnd_s;
`ifdef FPU_STATUS_EN
      res_flags = {s1_inv_r, s1_dbz_r,
                   !s1_spec_r & (rnd_s[30:23] == 8'hFF),
                   !s1_spec_r & (rnd_s[30:0] == 31'd0)};
`endif
   end

   assign res_valid = s1_valid_r;

endmodule

// File: rtl/fpu_abs_add_div.sv
// Binary32 fabs/fadd (1 cycle) and fdiv (2 cycles) execute unit with registered output.
// Optional status flags {invalid, div_by_zero, overflow, underflow} under FPU_STATUS_EN.
module fpu_abs_add_div
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  op,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic [31:0] y,
   output logic        out_valid
`ifdef FPU_STATUS_EN
   ,
   output logic [3:0]  flags
`endif
);

   fp_op_e            op_s;
   logic              issue_s, fast_issue_s, div_issue_s;
   fp32_t             a_s, b_s, big_s, sml_s;
   logic              swap_s;
   logic [7:0]        diff_s;
   logic [26:0]       big_ext_s, sml_ext_s, mask_s, aligned_s, norm_s;
   logic [27:0]       sum_s;
   logic [4:0]        lz_s;
   logic signed [9:0] nexp_s;
   logic [31:0]       gen_res_s, add_res_s, fast_res_s, div_res_s;
   logic              div_valid_s;

   logic [31:0]       y_r;
   logic              out_valid_r, in_ready_r;

`ifdef FPU_STATUS_EN
   logic [3:0]        add_flags_s, div_flags_s, flags_r;
   logic              add_gen_s;
`endif

   assign op_s         = fp_op_e'(op);
   assign issue_s      = in_valid & in_ready_r;
   assign div_issue_s  = issue_s & (op_s == FP_DIV);
   assign fast_issue_s = issue_s & (op_s != FP_DIV);

   // fadd: align with G/R/S, add or subtract magnitudes, normalize, round
   always_comb begin
      a_s       = fp32_t'(x1);
      b_s       = fp32_t'(x2);
      swap_s    = {b_s.exp, b_s.mant} > {a_s.exp, a_s.mant};
      big_s     = swap_s ? b_s : a_s;
      sml_s     = swap_s ? a_s : b_s;
      diff_s    = big_s.exp - sml_s.exp;
      big_ext_s = {1'b1, big_s.mant, 3'b000};
      sml_ext_s = {1'b1, sml_s.mant, 3'b000};
      mask_s    = (diff_s >= 8'd27) ? {27{1'b1}} : ((27'd1 << diff_s) - 27'd1);
      aligned_s = sml_ext_s >> diff_s;
      aligned_s[0] = aligned_s[0] | (|(sml_ext_s & mask_s));
      sum_s     = (big_s.sign == sml_s.sign) ? ({1'b0, big_ext_s} + {1'b0, aligned_s})
                                             : ({1'b0, big_ext_s} - {1'b0, aligned_s});
      lz_s      = lzc27(sum_s[26:0]);
      norm_s    = sum_s[27] ? {sum_s[27:2], sum_s[1] | sum_s[0]} : (sum_s[26:0] << lz_s);
      nexp_s    = sum_s[27] ? ($signed({2'b00, big_s.exp}) + 10'sd1)
                            : ($signed({2'b00, big_s.exp}) - $signed({5'd0, lz_s}));
      gen_res_s = round_pack(big_s.sign, nexp_s, norm_s);
      if (is_nan(a_s) || is_nan(b_s) ||
          (is_inf(a_s) && is_inf(b_s) && (a_s.sign != b_s.sign))) begin
         add_res_s = QNAN;
      end else if (is_inf(a_s)) begin
         add_res_s = x1;
      end else if (is_inf(b_s)) begin
         add_res_s = x2;
      end else if (is_zero(a_s) && is_zero(b_s)) begin
         add_res_s = {a_s.sign & b_s.sign, 31'd0};
      end else if (is_zero(a_s)) begin
         add_res_s = x2;
      end else if (is_zero(b_s)) begin
         add_res_s = x1;
      end else if (sum_s == 28'd0) begin
         add_res_s = 32'd0;
      end else begin
         add_res_s = gen_res_s;
      end
   end

`ifdef FPU_STATUS_EN
   // fadd flags: overflow/underflow only from the general datapath
   always_comb begin
      add_gen_s   = !is_nan(a_s) & !is_nan(b_s) & !is_inf(a_s) & !is_inf(b_s) &
                    !is_zero(a_s) & !is_zero(b_s) & (sum_s != 28'd0);
      add_flags_s = {is_snan(a_s) | is_snan(b_s) |
                     (is_inf(a_s) & is_inf(b_s) & (a_s.sign != b_s.sign)),
                     1'b0,
                     add_gen_s & (gen_res_s[30:23] == 8'hFF),
                     add_gen_s & (gen_res_s[30:0] == 31'd0)};
   end
`endif

   // Single-cycle result select; reserved op decodes as fabs
   always_comb begin
      case (op_s)
         FP_ADD:  fast_res_s = add_res_s;
         default: fast_res_s = {1'b0, x1[30:0]};
      endcase
   end

   fpu_div_core u_div (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (div_issue_s),
      .x1        (x1),
      .x2        (x2),
      .res_valid (div_valid_s),
      .res       (div_res_s)
`ifdef FPU_STATUS_EN
      ,
      .res_flags (div_flags_s)
`endif
   );

   // Output register; the bubble after an fdiv issue keeps completions apart
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_r         <= 32'd0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
`ifdef FPU_STATUS_EN
         flags_r     <= 4'd0;
`endif
      end else begin
         in_ready_r  <= !div_issue_s;
         out_valid_r <= div_valid_s | fast_issue_s;
         if (div_valid_s) begin
            y_r <= div_res_s;
         end else if (fast_issue_s) begin
            y_r <= fast_res_s;
         end
`ifdef FPU_STATUS_EN
         if (div_valid_s) begin
            flags_r <= div_flags_s;
         end else if (fast_issue_s) begin
            flags_r <= (op_s == FP_ADD) ? add_flags_s : 4'd0;
         end
`endif
      end
   end

   assign y         = y_r;
   assign out_valid = out_valid_r;
   assign in_ready  = in_ready_r;
`ifdef FPU_STATUS_EN
   assign flags     = flags_r;
`endif

endmodule

// File: tb/tb_fpu_abs_add_div.sv
// Scoreboard bench for fpu_abs_add_div: directed vectors push expected results with
// their completion cycle; a monitor pops and compares on every out_valid pulse.
module tb_fpu_abs_add_div;

   localparam logic [1:0] OP_ABS = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   logic        clk, rst, in_valid, in_ready, out_valid;
   logic [1:0]  op;
   logic [31:0] x1, x2, y;
`ifdef FPU_STATUS_EN
   logic [3:0]  flags;
`endif

   typedef struct {
      logic [31:0] y;
      logic [3:0]  f;
      int          cyc;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   fpu_abs_add_div dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .x1        (x1),
      .x2        (x2),
      .y         (y),
      .out_valid (out_valid)
`ifdef FPU_STATUS_EN
      ,
      .flags     (flags)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h", name, act, req);
      end
   endtask

   // Drive one request after a rising edge; it is sampled on the next one.
   task automatic send(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ey, input logic [3:0] ef,
                       input logic acc);
      exp_t e;
      @(posedge clk);
      #1;
      check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, acc});
      in_valid = 1'b1;
      op       = o;
      x1       = a;
      x2       = b;
      if (acc) begin
         e.y   = ey;
         e.f   = ef;
         e.cyc = cyc + ((o == OP_DIV) ? 2 : 1);
         e.tag = tag;
         sb_q.push_back(e);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 20) begin
         @(posedge clk);
         k++;
      end
      repeat (2) @(posedge clk);
      check({tag, ".outstanding"}, sb_q.size(), 32'd0);
   endtask

   // Monitor: every out_valid pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL spurious_out: y=%08h with nothing outstanding", y);
         end else begin
            mon_e = sb_q.pop_front();
            check({mon_e.tag, ".y"}, y, mon_e.y);
            check({mon_e.tag, ".cycle"}, cyc, mon_e.cyc);
`ifdef FPU_STATUS_EN
            check({mon_e.tag, ".flags"}, {28'd0, flags}, {28'd0, mon_e.f});
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      op       = OP_ABS;
      x1       = 32'd0;
      x2       = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset.y", y, 32'd0);
      check("reset.out_valid", {31'd0, out_valid}, 32'd0);
      check("reset.in_ready", {31'd0, in_ready}, 32'd1);
`ifdef FPU_STATUS_EN
      check("reset.flags", {28'd0, flags}, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;

      send("abs_pi",    OP_ABS, 32'hC0490FDB, 32'h0,        32'h40490FDB, 4'b0000, 1'b1);
      send("abs_nan",   OP_ABS, 32'hFFC00001, 32'h0,        32'h7FC00001, 4'b0000, 1'b1);
      send("abs_rsv",   OP_RSV, 32'h80000001, 32'h3F800000, 32'h00000001, 4'b0000, 1'b1);
      send("add_1p2",   OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1);
      send("add_cancel",OP_ADD, 32'h3F800000, 32'hBF800000, 32'h00000000, 4'b0000, 1'b1);
      send("add_infinf",OP_ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1'b1);
      send("add_tie_dn",OP_ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0000, 1'b1);
      send("add_tie_up",OP_ADD, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0000, 1'b1);
      send("add_ovf",   OP_ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0010, 1'b1);
      send("add_nzero", OP_ADD, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000, 1'b1);
      send("add_sub",   OP_ADD, 32'h40000000, 32'hBFC00000, 32'h3F000000, 4'b0000, 1'b1);
      send("add_ftz",   OP_ADD, 32'h00800000, 32'h80800001, 32'h80000000, 4'b0001, 1'b1);
      send("add_denorm",OP_ADD, 32'h00000001, 32'h00000000, 32'h00000000, 4'b0000, 1'b1);
      send("add_inf",   OP_ADD, 32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000, 1'b1);
      send("add_qnan",  OP_ADD, 32'h7FC12345, 32'h3F800000, 32'h7FC00000, 4'b0000, 1'b1);
      idle();
      drain("basic");

      // Divides, each followed by a refused request during the bubble
      send("div_third", OP_DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 1'b1);
      send("div_bubble",OP_ADD, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000, 1'b0);
      send("div_m2by0", OP_DIV, 32'hC0000000, 32'h00000000, 32'hFF800000, 4'b0100, 1'b1);
      idle();
      send("div_0by0",  OP_DIV, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1'b1);
      idle();
      send("div_1by0",  OP_DIV, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1'b1);
      idle();
      send("div_6by2",  OP_DIV, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1);
      idle();
      send("div_byinf", OP_DIV, 32'hBF800000, 32'h7F800000, 32'h80000000, 4'b0000, 1'b1);
      idle();
      send("div_ovf",   OP_DIV, 32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, 1'b1);
      idle();
      send("div_unf",   OP_DIV, 32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001, 1'b1);
      idle();
      drain("div");

      // Back-to-back single-cycle ops, then fdiv followed by fadd
      send("tp_add0",   OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1);
      send("tp_add1",   OP_ADD, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 1'b1);
      send("tp_add2",   OP_ADD, 32'h40400000, 32'h3F800000, 32'h40800000, 4'b0000, 1'b1);
      send("tp_add3",   OP_ADD, 32'h3F000000, 32'h3E800000, 32'h3F400000, 4'b0000, 1'b1);
      send("tp_div",    OP_DIV, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1);
      send("tp_ignored",OP_ADD, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 1'b0);
      send("tp_after",  OP_ADD, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000, 1'b1);
      idle();
      drain("throughput");

      // Reset one cycle after an fdiv issue kills it
      send("rst_div",   OP_DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 1'b1);
      void'(sb_q.pop_back());
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      check("rst_mid.y", y, 32'd0);
      check("rst_mid.out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("rst_after.in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_after.y", y, 32'd0);
      send("post_rst",  OP_ABS, 32'hBF800000, 32'h0,        32'h3F800000, 4'b0000, 1'b1);
      idle();
      drain("reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
